// File: rtl/voice_fifo_frame_ctrl.sv
`timescale 1ns/1ps
// voice_fifo_frame_ctrl
//   Frame scheduler wrapped around the voice-change sample FIFO.
//   Write side: registers a non-stallable sample stream into the FIFO. Samples
//   that arrive while the FIFO is almost full (or full) are dropped and counted.
//   Read side: waits until a complete frame of FRAME_LEN samples is buffered.
//   It then bursts that frame to the pitch-shift processor over valid/ready,
//   marking the last sample of the frame with m_last.
//
// Ports
//   clk, tb_rst                         clock; asynchronous active-high reset
//   s_data, s_valid                     incoming sample stream (no backpressure)
//   fifo_wr_data, fifo_wr_en            FIFO write port (registered)
//   fifo_wr_full, fifo_almost_full      FIFO write-side flags
//   fifo_rd_data, fifo_rd_en            FIFO read port (data one cycle after en)
//   fifo_rd_empty, fifo_rd_water_level  FIFO read-side status
//   m_data, m_valid, m_ready, m_last    frame stream to the processor
//   busy                                frame being read or drained
//   frame_cnt                           completed frames (wraps)
//   drop_cnt                            dropped samples (saturates)
module voice_fifo_frame_ctrl #(
  parameter int DATA_W    = 16,
  parameter int LVL_W     = 12,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              tb_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_en,
  input  logic              fifo_wr_full,
  input  logic              fifo_almost_full,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_empty,
  input  logic [LVL_W-1:0]  fifo_rd_water_level,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0] FRAME_LVL  = LVL_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  iss_cnt;
  logic              iss_clr;
  logic [CNT_W-1:0]  out_cnt;
  logic              rd_pend;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              blocked;
  logic              accept;
  logic              fill;
  logic              pop;
  logic              last_hs;
  logic [2:0]        outstanding;

  // ---------------------------------------------------------------- write path
  assign blocked = fifo_almost_full | fifo_wr_full;
  assign accept  = s_valid & ~blocked;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      drop_cnt     <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_wr_data <= s_data;
      end
      if (s_valid && blocked && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------ read FSM
  // Skid entries plus the read whose data is still on fifo_rd_data; keeping
  // this below 2 guarantees the 2-entry buffer can never overflow.
  assign outstanding = {1'b0, occ} + {2'b00, rd_pend};

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    iss_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        iss_clr = 1'b1;
        if ((fifo_rd_water_level >= FRAME_LVL) && !fifo_rd_empty) begin
          state_nx = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        fifo_rd_en = (iss_cnt < FRAME_END) && !fifo_rd_empty && (outstanding < 3'd2);
        // DRAIN is entered as the final read of the frame is issued.
        if (fifo_rd_en && (iss_cnt == FRAME_LAST)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_hs) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      iss_cnt <= '0;
    end else if (iss_clr) begin
      iss_cnt <= '0;
    end else if (fifo_rd_en) begin
      iss_cnt <= iss_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------- output skid buffer
  assign fill    = rd_pend;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid && (out_cnt == FRAME_LAST);
  assign last_hs = pop & m_last;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_pend <= 1'b0;
      occ     <= 2'd0;
      head    <= '0;
      tail    <= '0;
    end else begin
      rd_pend <= fifo_rd_en;
      unique case ({fill, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= fifo_rd_data;
          end else begin
            tail <= fifo_rd_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (occ == 2'd1) begin
            head <= fifo_rd_data;
          end else begin
            head <= tail;
            tail <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------- frame bookkeeping
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      out_cnt   <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      if (m_last) begin
        out_cnt   <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_fifo_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for voice_fifo_frame_ctrl: behavioural sample FIFO plus a scoreboard
// that predicts the output sample stream from the accepted input samples.
module tb_voice_fifo_frame_ctrl;

  localparam int DW = 16;
  localparam int LW = 12;
  localparam int FL = 256;

  logic          clk = 1'b0;
  logic          tb_rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_wr_full;
  logic          fifo_almost_full;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  voice_fifo_frame_ctrl #(.DATA_W(DW), .LVL_W(LW), .FRAME_LEN(FL)) dut (
    .clk(clk), .tb_rst(tb_rst), .s_data(s_data), .s_valid(s_valid),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_full(fifo_wr_full),
    .fifo_almost_full(fifo_almost_full), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // ------------------------------------------------ behavioural 2048-deep FIFO
  logic [DW-1:0] mem [0:2047];
  logic [10:0]   wp, rp;
  int            cnt;

  assign fifo_wr_full        = (cnt >= 2048);
  assign fifo_almost_full    = (cnt > 1020);
  assign fifo_rd_empty       = (cnt == 0);
  assign fifo_rd_water_level = LW'(cnt);

  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wp <= '0; rp <= '0; cnt <= 0; fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en && !fifo_wr_full) begin
        mem[wp] <= fifo_wr_data;
        wp <= wp + 11'd1;
      end
      if (fifo_rd_en && !fifo_rd_empty) begin
        fifo_rd_data <= mem[rp];
        rp <= rp + 11'd1;
      end
      cnt <= cnt + ((fifo_wr_en && !fifo_wr_full) ? 1 : 0) - ((fifo_rd_en && !fifo_rd_empty) ? 1 : 0);
    end
  end

  // ------------------------------------------------------------ check helpers
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ------------------------------------------------------- m_ready driver
  logic ready_req   = 1'b1;
  logic toggle_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    m_ready = toggle_mode ? ~m_ready : ready_req;
  end

  // ----------------------------------------------------- scoreboard/monitor
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  int cyc = 0;
  int exp_drops = 0, hs_in_frame = 0, issued = 0, delivered = 0;
  int viol = 0, rd_seen = 0, wr_seen = 0;
  int last_end_cyc = -1, gap_max = 0;
  logic gap_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tb_rst) begin
      exp_q.delete();
      exp_drops = 0; hs_in_frame = 0; issued = 0; delivered = 0;
    end else begin
      if (s_valid) begin
        if (fifo_almost_full || fifo_wr_full) exp_drops++;
        else exp_q.push_back(s_data);
      end
      if (fifo_wr_en) wr_seen++;
      if (fifo_rd_en) begin
        rd_seen++;
        if (issued - delivered >= 2) viol++;
        if (fifo_rd_empty) viol++;
      end
      if (issued - delivered > 2) viol++;
      if (m_valid && !busy) viol++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sample_without_input", m_data, -1);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e);
          check("m_last", m_last, (hs_in_frame == FL - 1));
        end
        if (hs_in_frame == 0 && gap_en && last_end_cyc >= 0 && (cyc - last_end_cyc) > gap_max)
          gap_max = cyc - last_end_cyc;
        if (hs_in_frame == FL - 1) begin
          last_end_cyc = cyc;
          hs_in_frame = 0;
        end else begin
          hs_in_frame++;
        end
        delivered++;
      end
      if (fifo_rd_en) issued++;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic feed(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = base + DW'(i);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frame_cnt != 16'(target) && n < 5000) begin
      @(negedge clk); n++;
    end
    check("frame_cnt", frame_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, rd0, wr0;

  initial begin
    tb_rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_wr_en", fifo_wr_en, 0);
    check("rst_fifo_wr_data", fifo_wr_data, 0);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    tb_rst = 1'b0;

    // 1: single frame, samples 0..255
    wr0 = wr_seen;
    feed(256, 16'h0000);
    wait_frames(1);
    repeat (3) @(negedge clk);
    check("t1_wr_en_pulses", wr_seen - wr0, 256);
    check("t1_busy_idle", busy, 0);
    check("t1_drop_cnt", drop_cnt, 0);
    check("t1_all_delivered", exp_q.size(), 0);

    // 2: 255 samples must not start a frame; the 256th does
    rd0 = rd_seen;
    feed(255, 16'h1000);
    repeat (20) @(negedge clk);
    check("t2_no_read_255", rd_seen - rd0, 0);
    check("t2_busy_255", busy, 0);
    feed(1, 16'h1000 + 16'd255);
    n = 0;
    while (cnt < FL && n < 20) begin @(negedge clk); n++; end
    check("t2_level_reached", (cnt >= FL), 1);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("t2_read_start_within_2", (n <= 2), 1);
    wait_frames(2);

    // 3: m_ready toggling every cycle
    toggle_mode = 1'b1;
    feed(256, 16'h2000);
    wait_frames(3);
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_protocol_violations", viol, 0);
    check("t3_busy_idle", busy, 0);

    // 4: stalled output, continuous 1100 samples hit almost-full
    ready_req = 1'b0;
    repeat (3) @(posedge clk);
    feed(1100, 16'h3000);
    repeat (5) @(negedge clk);
    check("t4_drop_cnt_model", drop_cnt, exp_drops);
    check("t4_drop_cnt", drop_cnt, 76);
    check("t4_no_frame_while_stalled", frame_cnt, 3);
    check("t4_busy_stalled", busy, 1);
    ready_req = 1'b1;
    wait_frames(7);
    repeat (3) @(negedge clk);
    check("t4_all_delivered", exp_q.size(), 0);
    check("t4_protocol_violations", viol, 0);

    // 5: reset after 100 samples of a frame
    ready_req = 1'b0;
    feed(256, 16'h4000);
    ready_req = 1'b1;
    n = 0;
    while (hs_in_frame < 100 && n < 2000) begin @(posedge clk); n++; end
    check("t5_hundred_delivered", hs_in_frame, 100);
    #1;
    tb_rst = 1'b1;
    #1;
    check("t5_rst_m_valid", m_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_fifo_rd_en", fifo_rd_en, 0);
    check("t5_rst_m_last", m_last, 0);
    check("t5_rst_frame_cnt", frame_cnt, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    check("t5_rst_m_data", m_data, 0);
    repeat (2) @(posedge clk);
    #1;
    tb_rst = 1'b0;
    feed(256, 16'h5000);
    wait_frames(1);

    // 6: two frames back to back
    ready_req = 1'b0;
    feed(512, 16'h6000);
    repeat (3) @(negedge clk);
    last_end_cyc = -1; gap_max = 0; gap_en = 1'b1;
    ready_req = 1'b1;
    wait_frames(3);
    gap_en = 1'b0;
    n_checks++;
    if (gap_max > 0 && gap_max <= 4) n_pass++;
    else $display("FAIL t6_frame_gap: got %0d cycles between frames, required 1..4", gap_max);
    repeat (3) @(negedge clk);
    check("t6_all_delivered", exp_q.size(), 0);
    check("t6_busy_idle", busy, 0);
    check("t6_protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
